// File: rtl/key_loader.sv
// rtl/key_loader.sv - packs an MSB-first byte stream into four 32-bit key slots
// Optional even-parity check on each byte when KEY_LOADER_PARITY_EN is defined.
module key_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
`ifdef KEY_LOADER_PARITY_EN
    input  logic        byte_par,
    output logic        parity_err,
`endif
    input  logic [1:0]  rd_idx,
    output logic [31:0] rd_key,
    output logic [3:0]  slot_valid,
    output logic [1:0]  wr_ptr,
    output logic        keys_full,
    output logic        load_done
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        COMMIT = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [31:0] staging;
    logic [31:0] slot_mem [4];
    logic [4:0]  byte_lsb;
    logic        byte_bad;

    // Byte k lands at bit 24-8k; for a 2-bit k that is {~k, 3'b000}.
    assign byte_lsb = {~byte_idx, 3'b000};

`ifdef KEY_LOADER_PARITY_EN
    assign byte_bad = ^{byte_in, byte_par};
`else
    assign byte_bad = 1'b0;
`endif

    assign byte_ready = (state == LOAD) && !clear;
    assign rd_key     = slot_valid[rd_idx] ? slot_mem[rd_idx] : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            byte_idx   <= 2'd0;
            staging    <= 32'h0;
            slot_valid <= 4'b0000;
            wr_ptr     <= 2'd0;
            keys_full  <= 1'b0;
            load_done  <= 1'b0;
`ifdef KEY_LOADER_PARITY_EN
            parity_err <= 1'b0;
`endif
            for (int i = 0; i < 4; i++) begin
                slot_mem[i] <= 32'h0;
            end
        end else begin
            load_done <= 1'b0;
`ifdef KEY_LOADER_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (clear) begin
                state      <= LOAD;
                byte_idx   <= 2'd0;
                staging    <= 32'h0;
                slot_valid <= 4'b0000;
                wr_ptr     <= 2'd0;
                keys_full  <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (byte_valid) begin
                            if (byte_bad) begin
                                // Drop the partial word; committed slots stay intact.
                                byte_idx <= 2'd0;
                                staging  <= 32'h0;
`ifdef KEY_LOADER_PARITY_EN
                                parity_err <= 1'b1;
`endif
                            end else begin
                                staging[byte_lsb +: 8] <= byte_in;
                                byte_idx               <= byte_idx + 2'd1;
                                if (byte_idx == 2'd3) begin
                                    state <= COMMIT;
                                end
                            end
                        end
                    end
                    COMMIT: begin
                        slot_mem[wr_ptr]   <= staging;
                        slot_valid[wr_ptr] <= 1'b1;
                        load_done          <= 1'b1;
                        wr_ptr             <= wr_ptr + 2'd1;
                        if (wr_ptr == 2'd3) begin
                            state     <= FULL;
                            keys_full <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                    FULL: begin
                        state <= FULL;
                    end
                    default: begin
                        state <= LOAD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_loader.sv
// tb/tb_key_loader.sv - table-driven and directed checks for key_loader
module tb_key_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [1:0]  rd_idx;
    logic [31:0] rd_key;
    logic [3:0]  slot_valid;
    logic [1:0]  wr_ptr;
    logic        keys_full;
    logic        load_done;
`ifdef KEY_LOADER_PARITY_EN
    logic        byte_par;
    logic        parity_err;
    logic        par_flip;
    assign byte_par = (^byte_in) ^ par_flip;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    key_loader dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
`ifdef KEY_LOADER_PARITY_EN
        .byte_par   (byte_par),
        .parity_err (parity_err),
`endif
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .slot_valid (slot_valid),
        .wr_ptr     (wr_ptr),
        .keys_full  (keys_full),
        .load_done  (load_done)
    );

    typedef struct {
        logic        clr;
        logic        vld;
        logic [7:0]  b;
        logic [1:0]  idx;
        logic        e_rdy;
        logic        e_ld;
        logic [3:0]  e_sv;
        logic [1:0]  e_wp;
        logic        e_full;
        logic [31:0] e_key;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, input logic vld, input logic [7:0] b,
                       input logic [1:0] idx, input logic e_rdy, input logic e_ld,
                       input logic [3:0] e_sv, input logic [1:0] e_wp,
                       input logic e_full, input logic [31:0] e_key);
        vec_t v;
        v.clr = clr; v.vld = vld; v.b = b; v.idx = idx;
        v.e_rdy = e_rdy; v.e_ld = e_ld; v.e_sv = e_sv; v.e_wp = e_wp;
        v.e_full = e_full; v.e_key = e_key;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams one word MSB-first, optionally pausing after two bytes, then checks the commit timing.
    task automatic send_word(input logic [31:0] w, input int hold, input logic [1:0] slot,
                             input logic [3:0] exp_sv);
        logic ld_seen;
        ld_seen = 1'b0;
        rd_idx  = slot;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                byte_valid = 1'b0;
                for (int h = 0; h < hold; h++) begin
                    tick();
                    if (load_done || !byte_ready) ld_seen = 1'b1;
                end
            end
            byte_valid = 1'b1;
            byte_in    = w[31 - 8*k -: 8];
            tick();
            if (k < 3 && load_done) ld_seen = 1'b1;
        end
        byte_valid = 1'b0;
        #1;
        check("word early load_done", {31'd0, ld_seen}, 32'd0);
        check("commit byte_ready", {31'd0, byte_ready}, 32'd0);
        check("commit load_done", {31'd0, load_done}, 32'd0);
        check("commit old rd_key", rd_key, 32'h0);
        tick();
        check("done load_done", {31'd0, load_done}, 32'd1);
        check("done slot_valid", {28'd0, slot_valid}, {28'd0, exp_sv});
        check("done wr_ptr", {30'd0, wr_ptr}, {30'd0, slot + 2'd1});
        check("done rd_key", rd_key, w);
        tick();
        check("after load_done", {31'd0, load_done}, 32'd0);
    endtask

    initial begin
        logic [3:0]  mask;
        logic [31:0] key0;

        // REQ-034: first word after reset
        add(0, 1, 8'h01, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        add(0, 1, 8'h23, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        add(0, 1, 8'h45, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        add(0, 1, 8'h67, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 0, 32'h0);
        add(0, 0, 8'h00, 0, 1, 1, 4'h1, 1, 0, 32'h01234567);
        add(0, 0, 8'h00, 0, 1, 0, 4'h1, 1, 0, 32'h01234567);
        add(1, 0, 8'h00, 0, 0, 0, 4'h1, 1, 0, 32'h01234567);
        add(0, 0, 8'h00, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        // REQ-035: four back-to-back words; a byte offered during COMMIT must be ignored
        for (int w = 0; w < 4; w++) begin
            mask = 4'((1 << w) - 1);
            key0 = (w > 0) ? 32'hA0A1A2A3 : 32'h0;
            for (int k = 0; k < 4; k++) begin
                add(0, 1, 8'(8'hA0 + 16*w + k), 0, 1, (w > 0 && k == 0), mask, 2'(w), 0, key0);
            end
            add(0, 1, 8'hEE, 0, 0, 0, mask, 2'(w), 0, key0);
        end
        add(0, 1, 8'hEE, 3, 0, 1, 4'hF, 0, 1, 32'hD0D1D2D3);
        add(0, 1, 8'hEE, 0, 0, 0, 4'hF, 0, 1, 32'hA0A1A2A3);
        add(0, 1, 8'hEE, 1, 0, 0, 4'hF, 0, 1, 32'hB0B1B2B3);
        add(0, 1, 8'hEE, 2, 0, 0, 4'hF, 0, 1, 32'hC0C1C2C3);
        add(0, 0, 8'h00, 3, 0, 0, 4'hF, 0, 1, 32'hD0D1D2D3);
        // REQ-037: clear out of FULL, then clear coincident with the 4th byte
        add(1, 0, 8'h00, 0, 0, 0, 4'hF, 0, 1, 32'hA0A1A2A3);
        add(0, 1, 8'hF1, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        add(0, 1, 8'hF2, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        add(0, 1, 8'hF3, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        add(1, 1, 8'hF4, 0, 0, 0, 4'h0, 0, 0, 32'h0);
        add(0, 0, 8'h00, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        add(0, 0, 8'h00, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        add(0, 1, 8'h11, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        add(0, 1, 8'h22, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        add(0, 1, 8'h33, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        add(0, 1, 8'h44, 0, 1, 0, 4'h0, 0, 0, 32'h0);
        add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 0, 32'h0);
        add(0, 0, 8'h00, 0, 1, 1, 4'h1, 1, 0, 32'h11223344);

        rst = 1'b1; clear = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; rd_idx = 2'd0;
`ifdef KEY_LOADER_PARITY_EN
        par_flip = 1'b0;
`endif
        #2;
        check("reset slot_valid", {28'd0, slot_valid}, 32'd0);
        check("reset wr_ptr", {30'd0, wr_ptr}, 32'd0);
        check("reset keys_full", {31'd0, keys_full}, 32'd0);
        check("reset load_done", {31'd0, load_done}, 32'd0);
        check("reset rd_key", rd_key, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("post-reset byte_ready", {31'd0, byte_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            clear      = vecs[i].clr;
            byte_valid = vecs[i].vld;
            byte_in    = vecs[i].b;
            rd_idx     = vecs[i].idx;
            #1;
            check($sformatf("row%0d byte_ready", i), {31'd0, byte_ready}, {31'd0, vecs[i].e_rdy});
            check($sformatf("row%0d load_done", i), {31'd0, load_done}, {31'd0, vecs[i].e_ld});
            check($sformatf("row%0d slot_valid", i), {28'd0, slot_valid}, {28'd0, vecs[i].e_sv});
            check($sformatf("row%0d wr_ptr", i), {30'd0, wr_ptr}, {30'd0, vecs[i].e_wp});
            check($sformatf("row%0d keys_full", i), {31'd0, keys_full}, {31'd0, vecs[i].e_full});
            check($sformatf("row%0d rd_key", i), rd_key, vecs[i].e_key);
            @(posedge clk);
            #1;
        end
        clear = 1'b0;
        byte_valid = 1'b0;

        // REQ-038: asynchronous reset mid-word, then a fresh word lands in slot 0
        byte_valid = 1'b1; byte_in = 8'hAA; tick();
        byte_in = 8'hBB; tick();
        byte_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async rst slot_valid", {28'd0, slot_valid}, 32'd0);
        check("async rst wr_ptr", {30'd0, wr_ptr}, 32'd0);
        check("async rst rd_key", rd_key, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_word(32'hDEADBEEF, 0, 2'd0, 4'b0001);

        // REQ-036: partial word held for 10 idle cycles
        send_word(32'h61626364, 10, 2'd1, 4'b0011);
        rd_idx = 2'd0;
        #1;
        check("slot0 retained", rd_key, 32'hDEADBEEF);

`ifdef KEY_LOADER_PARITY_EN
        // REQ-039: bad parity on the 2nd byte discards the partial word
        rd_idx = 2'd2;
        byte_valid = 1'b1; byte_in = 8'h71; tick();
        byte_in = 8'h72; par_flip = 1'b1; tick();
        par_flip = 1'b0; byte_valid = 1'b0;
        #1;
        check("parity_err pulse", {31'd0, parity_err}, 32'd1);
        check("parity no load_done", {31'd0, load_done}, 32'd0);
        check("parity byte_ready", {31'd0, byte_ready}, 32'd1);
        tick();
        check("parity_err cleared", {31'd0, parity_err}, 32'd0);
        check("parity wr_ptr", {30'd0, wr_ptr}, 32'd2);
        check("parity slot_valid", {28'd0, slot_valid}, 32'h3);
        send_word(32'h5A5B5C5D, 0, 2'd2, 4'b0111);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
